// File: rtl/ex_pkg.sv
// ex_pkg: shared constants and types for the execute-stage ALU.
//   ALUOP_W        : width of the aluop code
//   RESULT_DEFAULT : value loaded into alu_result on reset and on an illegal opcode
//   aluop_e        : operation encodings (codes 11..15 are illegal)
//   state_e        : control FSM states
package ex_pkg;

  localparam int unsigned ALUOP_W        = 4;
  localparam int unsigned RESULT_DEFAULT = 0;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_OR   = 4'd0,
    ALU_AND  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10
  } aluop_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL_RUN
  } state_e;

endpackage

// File: rtl/ex_alu_if.sv
// ex_alu_if: operation/result handshake bundle for ex_alu.
//   Request : in_valid/in_ready, pc_en, imm_en, pc, reg_1, reg_2, imm, aluop
//   Response: out_valid/out_ready, alu_result, op_err
//   Status  : busy
// master = producer of operations / consumer of results; slave = the ALU.
interface ex_alu_if #(
  parameter int DATA_W = 32
);
  import ex_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 pc_en;
  logic                 imm_en;
  logic [DATA_W-1:0]    pc;
  logic [DATA_W-1:0]    reg_1;
  logic [DATA_W-1:0]    reg_2;
  logic [DATA_W-1:0]    imm;
  logic [ALUOP_W-1:0]   aluop;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    alu_result;
  logic                 op_err;
  logic                 busy;

  modport master (
    output in_valid, pc_en, imm_en, pc, reg_1, reg_2, imm, aluop, out_ready,
    input  in_ready, out_valid, alu_result, op_err, busy
  );

  modport slave (
    input  in_valid, pc_en, imm_en, pc, reg_1, reg_2, imm, aluop, out_ready,
    output in_ready, out_valid, alu_result, op_err, busy
  );

endinterface

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst : clock, synchronous active-high reset
//   start    : load operands a/b and begin iterating
//   a, b     : multiplicand / multiplier, sampled only when start is high
//   done     : high during the last of DATA_W iteration cycles
//   product  : low DATA_W bits of a*b, valid while done is high
module ex_mul_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W);

  logic              run_q, run_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] acc_step;

  // The final partial product is summed combinationally so the result is
  // ready on the same edge that ends the last iteration cycle.
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = run_q && (cnt_q == CNT_W'(DATA_W - 1));
    product  = acc_step;
  end

  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      run_d    = 1'b1;
      cnt_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
    end else if (run_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (done) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/ex_alu.sv
// ex_alu: execute-stage ALU with valid/ready handshakes on both sides.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ex_alu_if slave (operation in, registered result out, busy)
// Single-cycle ops deliver their result one edge after accept. Illegal
// opcodes complete the same way with alu_result=0 and op_err=1.
// Build option: define EX_MUL_EN to add the iterative multiplier (aluop 10,
// DATA_W iteration cycles); without it code 10 is illegal and busy is 0.
module ex_alu
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic    clk,
  input  logic    rst,
  ex_alu_if.slave bus
);

  localparam int SHAMT_W = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic              op_err_q, op_err_d;

  logic [DATA_W-1:0] op_a, op_b;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0] alu_res;
  logic              alu_err;
  logic              accept;

  assign bus.in_ready   = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = alu_result_q;
  assign bus.op_err     = op_err_q;
  assign accept         = bus.in_valid && bus.in_ready;

  always_comb begin
    op_a    = bus.pc_en  ? bus.pc  : bus.reg_1;
    op_b    = bus.imm_en ? bus.imm : bus.reg_2;
    shamt   = op_b[SHAMT_W-1:0];
    alu_res = '0;
    alu_err = 1'b0;
    case (bus.aluop)
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
`ifdef EX_MUL_EN
      ALU_MUL:  alu_res = '0;
`endif
      default: begin
        alu_res = DATA_W'(RESULT_DEFAULT);
        alu_err = 1'b1;
      end
    endcase
  end

`ifdef EX_MUL_EN
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  assign mul_start = accept && (bus.aluop == ALU_MUL);
  assign bus.busy  = (state_q == ST_MUL_RUN);

  ex_mul_seq #(
    .DATA_W(DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign bus.busy = 1'b0;
`endif

  // Consumption clears out_valid first; a result loading on the same edge
  // then re-asserts it, so back-to-back ops keep out_valid high.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    alu_result_d = alu_result_q;
    op_err_d     = op_err_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef EX_MUL_EN
          if (bus.aluop == ALU_MUL) begin
            state_d = ST_MUL_RUN;
          end else
`endif
          begin
            alu_result_d = alu_res;
            op_err_d     = alu_err;
            out_valid_d  = 1'b1;
          end
        end
      end
      ST_MUL_RUN: begin
`ifdef EX_MUL_EN
        if (mul_done) begin
          alu_result_d = mul_product;
          op_err_d     = 1'b0;
          out_valid_d  = 1'b1;
          state_d      = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      alu_result_q <= DATA_W'(RESULT_DEFAULT);
      op_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      alu_result_q <= alu_result_d;
      op_err_q     <= op_err_d;
    end
  end

endmodule

// File: tb/tb_ex_alu.sv
// tb_ex_alu: directed, table-driven bench for ex_alu (DATA_W=32).
// Inputs are driven and outputs sampled on the falling clock edge.
// Define EX_MUL_EN for the multiply sequences; otherwise code 10 is checked
// as illegal.
module tb_ex_alu;
  import ex_pkg::*;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_alu_if #(.DATA_W(DATA_W)) bus ();

  ex_alu #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  aluop;
    logic        pc_en;
    logic        imm_en;
    logic [31:0] pc;
    logic [31:0] reg_1;
    logic [31:0] reg_2;
    logic [31:0] imm;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] op, input logic pce,
                              input logic ime, input logic [31:0] pcv, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] iv,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = nm; v.aluop = op; v.pc_en = pce; v.imm_en = ime;
    v.pc = pcv; v.reg_1 = r1; v.reg_2 = r2; v.imm = iv;
    v.exp_res = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.aluop  = op;
    bus.pc_en  = 1'b0;
    bus.imm_en = 1'b0;
    bus.reg_1  = a;
    bus.reg_2  = b;
    bus.pc     = 32'h0;
    bus.imm    = 32'h0;
  endtask

  // Watchdog: every sequence below is a fixed number of cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(4'd0, 32'h0, 32'h0);

    vecs.push_back(mk("add_wrap", 4'd3, 0, 1, 32'h0, 32'hFFFF_FFFF, 32'h5, 32'h1, 32'h0, 0));
    vecs.push_back(mk("sra",      4'd7, 1, 0, 32'h8000_0000, 32'h1, 32'h24, 32'h0, 32'hF800_0000, 0));
    vecs.push_back(mk("slt",      4'd8, 0, 0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h7, 32'h1, 0));
    vecs.push_back(mk("sltu",     4'd9, 0, 0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h7, 32'h0, 0));
    vecs.push_back(mk("or",       4'd0, 0, 0, 32'h0, 32'hF0F0_0000, 32'h0000_F0F0, 32'h0, 32'hF0F0_F0F0, 0));
    vecs.push_back(mk("and",      4'd1, 0, 0, 32'h0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 32'h0F00_0F00, 0));
    vecs.push_back(mk("xor",      4'd2, 0, 0, 32'h0, 32'hAAAA_5555, 32'hFFFF_0000, 32'h0, 32'h5555_5555, 0));
    vecs.push_back(mk("sub_wrap", 4'd4, 0, 0, 32'h0, 32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 0));
    vecs.push_back(mk("sll_mask", 4'd5, 0, 0, 32'h0, 32'h3, 32'h21, 32'h0, 32'h6, 0));
    vecs.push_back(mk("srl_31",   4'd6, 0, 1, 32'h0, 32'h8000_0000, 32'h0, 32'h1F, 32'h1, 0));
    vecs.push_back(mk("pc_sel",   4'd3, 1, 1, 32'h100, 32'hDEAD, 32'h9, 32'h4, 32'h104, 0));
    vecs.push_back(mk("illeg12",  4'd12, 0, 0, 32'h0, 32'h5, 32'h6, 32'h0, 32'h0, 1));
    vecs.push_back(mk("legal_after", 4'd4, 0, 0, 32'h0, 32'h10, 32'h3, 32'h0, 32'hD, 0));
    vecs.push_back(mk("illeg15",  4'd15, 0, 0, 32'h0, 32'h5, 32'h6, 32'h0, 32'h0, 1));
`ifndef EX_MUL_EN
    vecs.push_back(mk("mul_off",  4'd10, 0, 0, 32'h0, 32'h3, 32'h4, 32'h0, 32'h0, 1));
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_result",    64'(bus.alu_result), 64'h0);
    chk("rst_op_err",    64'(bus.op_err), 64'h0);
    chk("rst_busy",      64'(bus.busy), 64'h0);
    chk("rst_in_ready",  64'(bus.in_ready), 64'h1);

    // Vector table, one op at a time with latency 1
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.aluop = vecs[i].aluop; bus.pc_en = vecs[i].pc_en; bus.imm_en = vecs[i].imm_en;
      bus.pc = vecs[i].pc; bus.reg_1 = vecs[i].reg_1; bus.reg_2 = vecs[i].reg_2;
      bus.imm = vecs[i].imm;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      // Operands change after accept; the held result must not follow them.
      bus.reg_1 = ~vecs[i].reg_1; bus.pc = ~vecs[i].pc; bus.imm = ~vecs[i].imm;
      chk({vecs[i].name, "_valid"}, 64'(bus.out_valid), 64'h1);
      chk({vecs[i].name, "_res"},   64'(bus.alu_result), 64'(vecs[i].exp_res));
      chk({vecs[i].name, "_err"},   64'(bus.op_err), 64'(vecs[i].exp_err));
    end
    @(negedge clk);
    chk("drained_valid", 64'(bus.out_valid), 64'h0);

    // Backpressure: first result held while out_ready=0, then drain in order
    bus.out_ready = 1'b0;
    drive(4'd3, 32'd1, 32'd1);            // 2
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive(4'd3, 32'd10, 32'd20);          // 30, offered while stalled
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", 64'(bus.out_valid), 64'h1);
      chk("bp_hold_res",   64'(bus.alu_result), 64'd2);
      chk("bp_in_ready",   64'(bus.in_ready), 64'h0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_op2_valid", 64'(bus.out_valid), 64'h1);
    chk("bp_op2_res",   64'(bus.alu_result), 64'd30);
    drive(4'd4, 32'd100, 32'd1);          // 99
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_op3_valid", 64'(bus.out_valid), 64'h1);
    chk("bp_op3_res",   64'(bus.alu_result), 64'd99);
    @(negedge clk);
    chk("bp_done_valid", 64'(bus.out_valid), 64'h0);

`ifdef EX_MUL_EN
    // Multiply: busy for 32 cycles, result on edge 33
    drive(4'd10, 32'h1234_5678, 32'h0);
    bus.imm_en = 1'b1; bus.imm = 32'h10;
    bus.in_valid = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.reg_1 = 32'h0; bus.imm = 32'h0;
      chk($sformatf("mul_busy_%0d", k),  64'(bus.busy), 64'h1);
      chk($sformatf("mul_rdy_%0d", k),   64'(bus.in_ready), 64'h0);
      chk($sformatf("mul_ovld_%0d", k),  64'(bus.out_valid), 64'h0);
    end
    @(negedge clk);
    chk("mul_valid", 64'(bus.out_valid), 64'h1);
    chk("mul_res",   64'(bus.alu_result), 64'h2345_6780);
    chk("mul_err",   64'(bus.op_err), 64'h0);
    chk("mul_busy_end", 64'(bus.busy), 64'h0);
    @(negedge clk);

    // Reset 5 cycles into a multiply aborts it
    drive(4'd10, 32'h3, 32'h5);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_valid", 64'(bus.out_valid), 64'h0);
    chk("mrst_busy",  64'(bus.busy), 64'h0);
    chk("mrst_ready", 64'(bus.in_ready), 64'h1);
    chk("mrst_res",   64'(bus.alu_result), 64'h0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
        chk("mrst_no_result", {62'h0, bus.busy, bus.out_valid}, 64'h0);
    end
    chk("mrst_quiet", {62'h0, bus.busy, bus.out_valid}, 64'h0);
`endif

    // Reset concurrent with an accept wins
    drive(4'd3, 32'h7, 32'h8);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_rst_res", 64'(bus.alu_result), 64'hF);
    drive(4'd3, 32'h1, 32'h1);
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("crst_valid", 64'(bus.out_valid), 64'h0);
    chk("crst_res",   64'(bus.alu_result), 64'h0);

    // Normal ADD after reset
    drive(4'd3, 32'h40, 32'h2);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("post_rst_valid", 64'(bus.out_valid), 64'h1);
    chk("post_rst_res",   64'(bus.alu_result), 64'h42);
    chk("post_rst_err",   64'(bus.op_err), 64'h0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_alu.md
EX_ALU -- requirements
Module: ex_alu

Interface
REQ-001 Parameter DATA_W, default 32: operand and result width in bits, legal values 8..64.
REQ-002 Parameter SHAMT_W, default $clog2(DATA_W): shift-amount width, derived and not overridden.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operation offered; in_ready  out  1  operation accepted when both are high in the same cycle.
REQ-006 pc_en  in  1  operand A = pc when 1, else reg_1; imm_en  in  1  operand B = imm when 1, else reg_2.
REQ-007 pc, reg_1, reg_2, imm  in  DATA_W each  operand sources.
REQ-008 aluop  in  4  operation code, encodings from ex_pkg.
REQ-009 out_valid  out  1  result available; out_ready  in  1  result consumed when both are high.
REQ-010 alu_result  out  DATA_W  registered result; op_err  out  1  registered flag for an illegal opcode; busy  out  1  high while a multiply iterates.

Function
REQ-011 Encodings SHALL be OR=0, AND=1, XOR=2, ADD=3, SUB=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, MUL=10; codes 11..15 are illegal.
REQ-012 Operand select (REQ-006) SHALL be sampled only in the accept cycle; operands need not stay stable afterwards.
REQ-013 ADD/SUB SHALL wrap modulo 2^DATA_W with no carry or overflow output.
REQ-014 Shifts SHALL use B[SHAMT_W-1:0] only; SRA replicates A[DATA_W-1].
REQ-015 SLT/SLTU SHALL return 1 or 0 zero-extended to DATA_W (SLT signed, SLTU unsigned).
REQ-016 Single-cycle ops SHALL set alu_result/op_err and raise out_valid on the edge following accept (latency 1).
REQ-017 FSM states SHALL be IDLE and MUL_RUN; IDLE->MUL_RUN on MUL accept; MUL_RUN->IDLE after exactly DATA_W iteration cycles.
REQ-018 MUL SHALL be unsigned shift-add and return the low DATA_W bits of A*B; out_valid rises DATA_W+1 edges after accept.
REQ-019 busy SHALL equal (state==MUL_RUN).
REQ-020 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready), so back-to-back single-cycle ops sustain one per cycle.
REQ-021 While out_valid && !out_ready, alu_result and op_err SHALL hold unchanged.
REQ-022 out_valid SHALL fall on the edge after out_valid && out_ready unless a new result loads on that same edge, in which case it stays high.
REQ-023 Illegal opcode SHALL complete with latency 1, alu_result=0, op_err=1; legal ops set op_err=0.
REQ-024 in_valid with in_ready low SHALL be ignored and cause no state change.

Reset
REQ-025 rst SHALL force state=IDLE, out_valid=0, alu_result=0, op_err=0, busy=0, iteration counter=0.
REQ-026 rst during MUL_RUN SHALL abort the multiply with no result delivered; rst has priority over all other events.

Configuration
REQ-027 Macro EX_MUL_EN SHALL gate MUL: defined -> MUL per REQ-017/018; undefined -> no multiplier logic, MUL_RUN unreachable, busy tied 0, and code 10 treated as illegal per REQ-023.

Structure
REQ-028 Package ex_pkg SHALL hold the aluop encodings, the aluop width constant (4) and the default result constant (0).
REQ-029 The iterative multiplier SHALL be the sub-module ex_mul_seq (start, operands, done, product), instantiated only under EX_MUL_EN.

Verification
REQ-030 DATA_W=32: ADD A=0xFFFFFFFF, B=1 -> next cycle out_valid=1, alu_result=0, op_err=0.
REQ-031 SRA A=0x80000000, B=0x24 -> alu_result=0xF8000000 (shift 4); SLT A=-1, B=1 -> 1; SLTU on the same operands -> 0.
REQ-032 EX_MUL_EN defined: MUL 0x12345678*0x10 -> busy for 32 cycles, in_ready=0 throughout, alu_result=0x23456780 on edge 33.
REQ-033 out_ready=0 with 3 ops offered -> first result held, in_ready=0; then out_ready=1 -> results drained one per cycle in order.
REQ-034 aluop=12 -> alu_result=0, op_err=1; with EX_MUL_EN undefined, aluop=10 -> op_err=1.
REQ-035 rst asserted 5 cycles into a MUL -> next cycle state=IDLE, out_valid=0, busy=0; a following ADD completes normally.
